mem_copy_dma: RTL

Block-copy engine that initiates word transfers on the data-memory port of the single-cycle MIPS design. On `start` it reads `len` consecutive words from `src_addr` and writes them to `dst_addr`, one word at a time. It drives the memory's `addr`, `data_in` and `write_enable` inputs and consumes its combinational `data_out`. Use it for memory initialisation and testbench preload without stalling the core's datapath. A mux outside this block selects the core or the engine as the memory master.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/mem_copy_dma_if.sv | 26 ++
 rtl/mem_copy_dma.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS data memory and its copy engine.
package mips_mem_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Data-memory port bundle: master drives addr/wdata/we, slave returns rdata.
interface mem_copy_dma_if #(
    parameter int ADDR_W = mips_mem_pkg::ADDR_W,
    parameter int DATA_W = mips_mem_pkg::DATA_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word forward block copy engine for the data-memory port.
// MEM_COPY_DMA_FILL_EN adds a write-only fill mode (fill_mode/fill_value).
module mem_copy_dma #(
    parameter int MEM_DEPTH = mips_mem_pkg::MEM_DEPTH,
    parameter int DATA_W    = mips_mem_pkg::DATA_W,
    parameter int ADDR_W    = mips_mem_pkg::ADDR_W,
    parameter int LEN_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef MEM_COPY_DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    mem_copy_dma_if.master    bus
);

    import mips_mem_pkg::*;

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(MEM_DEPTH - 1);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fill_q, fill_d;
    logic              req_fill;
    logic [DATA_W-1:0] req_value;

`ifdef MEM_COPY_DMA_FILL_EN
    assign req_fill  = fill_mode;
    assign req_value = fill_value;
`else
    assign req_fill  = 1'b0;
    assign req_value = '0;
`endif

    // wdata_q doubles as the data register: loaded at the end of READ
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src_addr & MASK;
                    dst_d  = dst_addr & MASK;
                    cnt_d  = len;
                    fill_d = req_fill;
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (req_fill) begin
                        state_d = WRITE;
                        busy_d  = 1'b1;
                        addr_d  = dst_d;
                        wdata_d = req_value;
                        we_d    = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                        addr_d  = src_d;
                    end
                end
            end
            READ: begin
                state_d = WRITE;
                busy_d  = 1'b1;
                addr_d  = dst_q;
                wdata_d = bus.mem_rdata;
                we_d    = 1'b1;
            end
            WRITE: begin
                src_d = (src_q + 1'b1) & MASK;
                dst_d = (dst_q + 1'b1) & MASK;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q > LEN_W'(1)) begin
                    busy_d = 1'b1;
                    if (fill_q) begin
                        state_d = WRITE;
                        addr_d  = dst_d;
                        wdata_d = wdata_q;
                        we_d    = 1'b1;
                    end else begin
                        state_d = READ;
                        addr_d  = src_d;
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;

endmodule
